proteus_nbout_wb_buffer: RTL
============================

Name: proteus_nbout_wb_buffer

Overview:
- Write-back stage directly downstream of the Proteus top pipeline's NBout packer.
- Captures each packed Tn-lane word the packer produces into a FIFO. Drains the FIFO to the memory interface with a valid/ready handshake and generates sequential write addresses.
- A per-tile FSM counts expected words, reports busy/done, and flags overflow. The pipeline cannot stall, so words are never back-pressured; the buffer only signals almost-full.

Parameters:
- BIT_WIDTH, 16, width of one lane value.
- Tn, 16, lanes per packed word; data width is BIT_WIDTH*Tn.
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- PTR_BITS, 3, log2(DEPTH).
- ADDR_BITS, 16, memory word-address width.
- CNT_BITS, 16, width of the word counters.
- AFULL_LVL, 6, occupancy at or above which o_almost_full asserts.

Ports:
- clk  in  1  main clock.
- rst  in  1  reset; synchronous, active-high.
- i_start  in  1  one-cycle pulse; begins a tile. Sampled only in IDLE or DONE.
- i_num_words  in  CNT_BITS  words expected in this tile; latched on i_start.
- i_base_addr  in  ADDR_BITS  first memory address; latched on i_start.
- i_valid  in  1  packer word valid this cycle.
- i_data  in  BIT_WIDTH*Tn  packed word from the NBout packer.
- i_mem_ready  in  1  memory accepts the current beat.
- o_mem_valid  out  1  FIFO head is valid.
- o_mem_data  out  BIT_WIDTH*Tn  FIFO head word.
- o_mem_addr  out  ADDR_BITS  address of the head word.
- o_almost_full  out  1  occupancy >= AFULL_LVL.
- o_busy  out  1  state is RUN or DRAIN.
- o_done  out  1  one-cycle pulse when the tile has been fully written to memory.
- o_overflow  out  1  sticky: a valid word was dropped.

Behaviour:
- Reset (rst high at a clk edge) produces, on the next cycle:
  - state IDLE;
  - FIFO pointers, occupancy and both counters at 0;
  - o_mem_valid=0, o_mem_data=0, o_mem_addr=0;
  - o_almost_full=0, o_busy=0, o_done=0, o_overflow=0.
- rst overrides all other inputs. Reset mid-tile discards FIFO contents without issuing any further beats.

FSM states and transitions:
- IDLE --i_start--> RUN. If latched i_num_words==0, go IDLE --i_start--> DONE instead.
- RUN: accepts words. When accepted count reaches num_words (including the accepting cycle), go to DRAIN on the next edge.
- DRAIN: when issued count reaches num_words (the last beat handshakes), go to DONE.
- DONE: o_done=1 for exactly that cycle. Next state is IDLE, or RUN if i_start is high that cycle.

Write side:
- Push when i_valid=1 and state=RUN and FIFO is not full.
- i_valid outside RUN is ignored and does not set overflow.
- i_valid in RUN with the FIFO full and no pop that cycle: word dropped, o_overflow set. The dropped word does not advance the accepted count.
- Full FIFO with simultaneous pop: push is accepted and occupancy is unchanged.
- i_valid in RUN after num_words have been accepted cannot occur, because the state has already left RUN.

Read side:
- Show-ahead FIFO; o_mem_valid = occupancy != 0.
- A word pushed at edge t is presented on o_mem_valid/o_mem_data in the cycle after edge t (1-cycle latency, empty FIFO).
- A pop occurs on an edge where o_mem_valid && i_mem_ready. Once asserted, o_mem_data and o_mem_addr are held stable until the pop.
- o_mem_addr = base_addr + issued_count, truncated to ADDR_BITS (wraps modulo 2^ADDR_BITS).
- Empty FIFO with push and ready in the same cycle: no pop that cycle; the word pops at the earliest the following edge.

Pointers and flags:
- Pointers wrap modulo DEPTH; occupancy ranges 0..DEPTH.
- o_overflow clears only on rst or on an accepted i_start.
- o_almost_full is registered from the next-state occupancy.
- i_start while RUN or DRAIN is ignored; latched values are unchanged.

Test Plan:
- Basic tile: i_base_addr=0x100, i_num_words=4, 4 consecutive words 0xA0..0xA3 in RUN, i_mem_ready=1 -> beats at addrs 0x100..0x103 with data in order, first beat the cycle after the first push, o_done pulses once, then IDLE.
- Backpressure: i_num_words=8, 8 consecutive pushes, i_mem_ready=0 -> occupancy reaches 8, o_almost_full asserts when occupancy reaches 6, o_mem_data/addr held. Release ready -> 8 beats in order, o_done pulses, o_overflow=0.
- Overflow: DEPTH=8, i_num_words=10, i_mem_ready=0, 10 pushes -> 9th and 10th words dropped, o_overflow=1, FSM stays RUN. Next i_start after rst or DONE clears o_overflow.
- Full with simultaneous pop: FIFO full, i_valid=1 and i_mem_ready=1 in the same cycle -> push accepted, occupancy stays 8, o_overflow remains 0.
- Zero-length and address wrap:
  - i_num_words=0 -> o_done the cycle after i_start, no beats.
  - i_base_addr=0xFFFE, i_num_words=3 -> addrs 0xFFFE, 0xFFFF, 0x0000.
- Reset mid-DRAIN: rst asserted with 3 words buffered -> the next cycle o_mem_valid=0, o_busy=0, IDLE; a new tile then runs cleanly with addresses starting from the new base.

Source files
------------

// File: rtl/proteus_nbout_wb_buffer.sv
// Write-back buffer behind the NBout packer: captures packed words into a show-ahead FIFO
// and drains them to memory with sequential addresses, tracking one tile at a time.
module proteus_nbout_wb_buffer #(
   parameter int BIT_WIDTH = 16,
   parameter int Tn        = 16,
   parameter int DEPTH     = 8,
   parameter int PTR_BITS  = 3,
   parameter int ADDR_BITS = 16,
   parameter int CNT_BITS  = 16,
   parameter int AFULL_LVL = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_start,
   input  logic [CNT_BITS-1:0]       i_num_words,
   input  logic [ADDR_BITS-1:0]      i_base_addr,
   input  logic                      i_valid,
   input  logic [BIT_WIDTH*Tn-1:0]   i_data,
   input  logic                      i_mem_ready,
   output logic                      o_mem_valid,
   output logic [BIT_WIDTH*Tn-1:0]   o_mem_data,
   output logic [ADDR_BITS-1:0]      o_mem_addr,
   output logic                      o_almost_full,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_overflow,
   output logic [1:0]                o_state
);

   localparam int DW = BIT_WIDTH * Tn;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [PTR_BITS:0] OCC_FULL  = (PTR_BITS+1)'(DEPTH);
   localparam logic [PTR_BITS:0] OCC_AFULL = (PTR_BITS+1)'(AFULL_LVL);

   // Memory handshake: a beat transfers on a clk edge where o_mem_valid && i_mem_ready;
   // o_mem_data/o_mem_addr stay stable from assertion of o_mem_valid until that beat.
   // The packer side has no ready: words arriving while full (and no pop) are dropped.

   logic [1:0]           state;
   logic [DW-1:0]        mem [DEPTH];
   logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
   logic [PTR_BITS:0]    occ, occ_next;
   logic [CNT_BITS-1:0]  acc_cnt, iss_cnt, num_words;
   logic [ADDR_BITS-1:0] base_addr;
   logic                 almost_full, overflow;
   logic                 empty, full, push, pop, drop, start_ok, acc_last, iss_last;

   always_comb begin
      empty    = (occ == '0);
      full     = (occ == OCC_FULL);
      pop      = !empty && i_mem_ready;
      push     = i_valid && (state == S_RUN) && (!full || pop);
      drop     = i_valid && (state == S_RUN) && full && !pop;
      start_ok = i_start && ((state == S_IDLE) || (state == S_DONE));
      acc_last = (acc_cnt + CNT_BITS'(1)) == num_words;
      iss_last = (iss_cnt + CNT_BITS'(1)) == num_words;
      occ_next = occ;
      if (push && !pop) begin
         occ_next = occ + (PTR_BITS+1)'(1);
      end else if (pop && !push) begin
         occ_next = occ - (PTR_BITS+1)'(1);
      end
   end

   // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         acc_cnt     <= '0;
         iss_cnt     <= '0;
         num_words   <= '0;
         base_addr   <= '0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         occ         <= occ_next;
         almost_full <= (occ_next >= OCC_AFULL);
         if (push) begin
            wr_ptr  <= wr_ptr + PTR_BITS'(1);
            acc_cnt <= acc_cnt + CNT_BITS'(1);
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + PTR_BITS'(1);
            iss_cnt <= iss_cnt + CNT_BITS'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         case (state)
            S_IDLE, S_DONE: begin
               if (start_ok) begin
                  num_words <= i_num_words;
                  base_addr <= i_base_addr;
                  acc_cnt   <= '0;
                  iss_cnt   <= '0;
                  overflow  <= 1'b0;
                  state     <= (i_num_words == '0) ? S_DONE : S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               if (push && acc_last) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && iss_last) begin
                  state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_mem_valid   = !empty;
      o_mem_data    = empty ? '0 : mem[rd_ptr];
      o_mem_addr    = base_addr + ADDR_BITS'(iss_cnt);
      o_almost_full = almost_full;
      o_busy        = (state == S_RUN) || (state == S_DRAIN);
      o_done        = (state == S_DONE);
      o_overflow    = overflow;
      o_state       = state;
   end

endmodule
